// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the CPU fetch stage. Each non-stalled cycle
//   it applies one op to pc: hold, increment, absolute jump, signed relative
//   branch, call (push return address onto an internal return-address stack)
//   or return (pop it). Stack overflow and underflow are flagged stickily until
//   err_clr.
//
//   All outputs come straight from registers (ras_full/ras_empty/ras_top are
//   decoded from registered state only), so there is no input-to-output
//   combinational path. There are no handshakes: the controller presents op,
//   and it takes effect at the next posedge unless stall is high.
//
// Ports
//   clk        in   clock, all state updates on posedge
//   rst        in   synchronous active-high reset, overrides everything
//   stall      in   1 = freeze pc and RAS this cycle (err_clr still honoured)
//   op         in   0 HOLD, 1 INC, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6-7 HOLD
//   new_adr    in   absolute target for JUMP and CALL
//   imm        in   two's-complement displacement for BRANCH
//   err_clr    in   clears ras_ovf and ras_unf
//   pc         out  current fetch address
//   ras_top    out  top RAS entry, 0 when empty
//   ras_count  out  number of valid RAS entries
//   ras_full   out  ras_count == RAS_DEPTH
//   ras_empty  out  ras_count == 0
//   ras_ovf    out  sticky: CALL issued while full
//   ras_unf    out  sticky: RET issued while empty
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                ADDR_W     = 16,
    parameter int                RAS_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [2:0]                   op,
    input  logic [ADDR_W-1:0]            new_adr,
    input  logic [ADDR_W-1:0]            imm,
    input  logic                         err_clr,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_full,
    output logic                         ras_empty,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_INC    = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_CALL   = 3'd4;
    localparam logic [2:0] OP_RET    = 3'd5;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  push_ptr;
    logic [PTR_W-1:0]  pop_ptr;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_branch;
    logic              push_en;

    // RAS_DEPTH is a power of two, so the pointer wraps by natural overflow.
    always_comb begin
        push_ptr  = ptr + PTR_W'(1);
        pop_ptr   = ptr - PTR_W'(1);
        pc_inc    = pc + ADDR_W'(1);
        pc_branch = pc + imm;   // modulo add handles negative imm
        push_en   = !rst && !stall && (op == OP_CALL);
    end

    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
    assign ras_empty = (ras_count == '0);
    // Stale storage is hidden while empty.
    assign ras_top   = ras_empty ? '0 : ras_mem[ptr];

    // Storage has no reset; validity is tracked by ras_count alone. A push
    // when full lands on the oldest entry, which is exactly the one the
    // circular pointer points past.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_mem[push_ptr] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_ADDR;
            ptr       <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else begin
            // Clear first so that an error raised below in the same cycle wins.
            if (err_clr) begin
                ras_ovf <= 1'b0;
                ras_unf <= 1'b0;
            end
            if (!stall) begin
                case (op)
                    OP_INC:    pc <= pc_inc;
                    OP_JUMP:   pc <= new_adr;
                    OP_BRANCH: pc <= pc_branch;
                    OP_CALL: begin
                        pc  <= new_adr;
                        ptr <= push_ptr;
                        if (ras_full) begin
                            ras_ovf <= 1'b1;
                        end else begin
                            ras_count <= ras_count + CNT_W'(1);
                        end
                    end
                    OP_RET: begin
                        if (ras_empty) begin
                            // Bad return falls through to the next instruction.
                            pc      <= pc_inc;
                            ras_unf <= 1'b1;
                        end else begin
                            pc        <= ras_mem[ptr];
                            ptr       <= pop_ptr;
                            ras_count <= ras_count - CNT_W'(1);
                        end
                    end
                    default: ;   // HOLD and illegal codes 6/7
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int          ADDR_W = 16;
    localparam int          DEPTH  = 8;
    localparam logic [15:0] RADDR  = 16'h0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  op;
    logic [15:0] new_adr;
    logic [15:0] imm;
    logic        err_clr;
    logic [15:0] pc;
    logic [15:0] ras_top;
    logic [3:0]  ras_count;
    logic        ras_full;
    logic        ras_empty;
    logic        ras_ovf;
    logic        ras_unf;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [15:0]       pc_model;

    // clock / reset
    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(16), .RAS_DEPTH(DEPTH), .RESET_ADDR(RADDR)) dut (
        .clk(clk), .rst(rst), .stall(stall), .op(op), .new_adr(new_adr),
        .imm(imm), .err_clr(err_clr), .pc(pc), .ras_top(ras_top),
        .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    // driver: inputs change 1 time unit after posedge, outputs sampled there too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [15:0] a, input logic [15:0] i);
        op = o; new_adr = a; imm = i;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; op = 3'd1; err_clr = 1'b0; new_adr = '0; imm = '0;
        step(); step();
        rst = 1'b0;
        checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 16'h0100); end
        checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got=%b%b exp=10", ras_empty, ras_full); end
        checks++; if (ras_top !== 16'h0000) begin errors++; $display("FAIL reset_top got=%h exp=0000", ras_top); end
        checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", ras_ovf, ras_unf); end
    endtask

    task automatic test_inc();
        for (int k = 1; k <= 3; k++) begin
            drive(3'd1, 16'h0, 16'h0);
            checks++; if (pc !== 16'h0100 + 16'(k)) begin errors++; $display("FAIL inc_%0d got=%h exp=%h", k, pc, 16'h0100 + 16'(k)); end
        end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL inc_empty got=%b exp=1", ras_empty); end
    endtask

    task automatic test_branch_wrap();
        drive(3'd2, 16'h0010, 16'h0);
        checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL jump got=%h exp=0010", pc); end
        drive(3'd3, 16'h0, 16'hFFFC);
        checks++; if (pc !== 16'h000C) begin errors++; $display("FAIL branch_neg got=%h exp=000C", pc); end
        drive(3'd3, 16'h0, 16'h0005);
        checks++; if (pc !== 16'h0011) begin errors++; $display("FAIL branch_pos got=%h exp=0011", pc); end
        drive(3'd2, 16'hFFFF, 16'h0);
        drive(3'd1, 16'h0, 16'h0);
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL inc_wrap got=%h exp=0000", pc); end
        drive(3'd2, 16'h0002, 16'h0);
        drive(3'd3, 16'h0, 16'hFFFD);
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL branch_wrap got=%h exp=FFFF", pc); end
        checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL branch_flags got=%b%b exp=00", ras_ovf, ras_unf); end
    endtask

    task automatic test_illegal_op();
        drive(3'd6, 16'h1234, 16'h0001);
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL op6_hold got=%h exp=FFFF", pc); end
        drive(3'd7, 16'h1234, 16'h0001);
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL op7_hold got=%h exp=FFFF", pc); end
        drive(3'd0, 16'h1234, 16'h0001);
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL op0_hold got=%h exp=FFFF", pc); end
    endtask

    task automatic test_call_ret();
        drive(3'd2, 16'h0020, 16'h0);
        drive(3'd4, 16'h0200, 16'h0);
        checks++; if (pc !== 16'h0200) begin errors++; $display("FAIL call_pc got=%h exp=0200", pc); end
        checks++; if (ras_top !== 16'h0021) begin errors++; $display("FAIL call_top got=%h exp=0021", ras_top); end
        checks++; if (ras_count !== 4'd1) begin errors++; $display("FAIL call_count got=%0d exp=1", ras_count); end
        drive(3'd5, 16'h0, 16'h0);
        checks++; if (pc !== 16'h0021) begin errors++; $display("FAIL ret_pc got=%h exp=0021", pc); end
        checks++; if (ras_count !== 4'd0 || ras_top !== 16'h0) begin errors++; $display("FAIL ret_count_top got=%0d/%h exp=0/0000", ras_count, ras_top); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        logic [15:0] tgt;
        exp_q.delete();
        drive(3'd2, 16'h0300, 16'h0);
        pc_model = 16'h0300;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(pc_model + 16'd1);
            if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            tgt = 16'h1000 + 16'(i * 16);
            drive(3'd4, tgt, 16'h0);
            pc_model = tgt;
            checks++; if (pc !== pc_model) begin errors++; $display("FAIL nest_call_%0d got=%h exp=%h", i, pc, pc_model); end
        end
        checks++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL nest_ovf got=%b exp=1", ras_ovf); end
        checks++; if (ras_count !== 4'd8 || ras_full !== 1'b1) begin errors++; $display("FAIL nest_full got=%0d/%b exp=8/1", ras_count, ras_full); end
        checks++; if (ras_top !== exp_q[$]) begin errors++; $display("FAIL nest_top got=%h exp=%h", ras_top, exp_q[$]); end
        for (int i = 0; i < 8; i++) begin
            exp = exp_q.pop_back();
            drive(3'd5, 16'h0, 16'h0);
            pc_model = exp;
            checks++; if (pc !== exp) begin errors++; $display("FAIL nest_ret_%0d got=%h exp=%h", i, pc, exp); end
            checks++; if (ras_count !== 4'(7 - i)) begin errors++; $display("FAIL nest_ret_cnt_%0d got=%0d exp=%0d", i, ras_count, 7 - i); end
        end
        checks++; if (ras_empty !== 1'b1 || ras_unf !== 1'b0) begin errors++; $display("FAIL nest_drained got=%b/%b exp=1/0", ras_empty, ras_unf); end
        drive(3'd5, 16'h0, 16'h0);
        checks++; if (ras_unf !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", ras_unf); end
        checks++; if (pc !== pc_model + 16'd1) begin errors++; $display("FAIL unf_pc got=%h exp=%h", pc, pc_model + 16'd1); end
        checks++; if (ras_count !== 4'd0 || ras_ovf !== 1'b1) begin errors++; $display("FAIL unf_cnt_ovf got=%0d/%b exp=0/1", ras_count, ras_ovf); end
        pc_model = pc_model + 16'd1;
    endtask

    task automatic test_stall_clear();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(3'd2, 16'hBEEF, 16'h0);
            checks++; if (pc !== pc_model) begin errors++; $display("FAIL stall_jump_%0d got=%h exp=%h", k, pc, pc_model); end
        end
        drive(3'd4, 16'hBEEF, 16'h0);
        checks++; if (pc !== pc_model || ras_count !== 4'd0) begin errors++; $display("FAIL stall_call got=%h/%0d exp=%h/0", pc, ras_count, pc_model); end
        checks++; if (ras_ovf !== 1'b1 || ras_unf !== 1'b1) begin errors++; $display("FAIL stall_flags_kept got=%b%b exp=11", ras_ovf, ras_unf); end
        err_clr = 1'b1;
        drive(3'd2, 16'hBEEF, 16'h0);
        err_clr = 1'b0;
        stall = 1'b0;
        checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL err_clr got=%b%b exp=00", ras_ovf, ras_unf); end
        checks++; if (pc !== pc_model) begin errors++; $display("FAIL err_clr_pc got=%h exp=%h", pc, pc_model); end
        // clear and a new underflow in the same cycle: set wins
        err_clr = 1'b1;
        drive(3'd5, 16'h0, 16'h0);
        err_clr = 1'b0;
        checks++; if (ras_unf !== 1'b1 || ras_ovf !== 1'b0) begin errors++; $display("FAIL set_wins got=%b%b exp=01", ras_ovf, ras_unf); end
        checks++; if (pc !== pc_model + 16'd1) begin errors++; $display("FAIL set_wins_pc got=%h exp=%h", pc, pc_model + 16'd1); end
    endtask

    task automatic test_reset_mid_call();
        drive(3'd4, 16'h0400, 16'h0);
        drive(3'd4, 16'h0500, 16'h0);
        drive(3'd4, 16'h0600, 16'h0);
        checks++; if (ras_count !== 4'd3 || ras_top !== 16'h0501) begin errors++; $display("FAIL pre_rst got=%0d/%h exp=3/0501", ras_count, ras_top); end
        rst = 1'b1;
        drive(3'd4, 16'h0700, 16'h0);
        rst = 1'b0;
        checks++; if (pc !== RADDR) begin errors++; $display("FAIL rst_mid_pc got=%h exp=%h", pc, RADDR); end
        checks++; if (ras_count !== 4'd0 || ras_top !== 16'h0) begin errors++; $display("FAIL rst_mid_ras got=%0d/%h exp=0/0000", ras_count, ras_top); end
        checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got=%b%b exp=00", ras_ovf, ras_unf); end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_branch_wrap();
        test_illegal_op();
        test_call_ret();
        test_back_to_back();
        test_stall_clear();
        test_reset_mid_call();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
